async_psram_responder: RTL and testbench
========================================

Name: async_psram_responder

Overview:
- Synthesizable responder side of the asynchronous PSRAM pin interface. Emulates a 16-bit async PSRAM: it samples CE/OE/WE/LB/UB/ADDR/DATA from an external initiator and stores data in an internal word array.
- Drives read data back onto the shared bus after a programmable access latency.
- Serves as an on-FPGA stand-in for the Micron part: board bring-up without the PSRAM populated, and loopback regression of the PSRAM controller against a cycle-true memory.

Parameters:
- ADDR_W, 10, implemented address bits; depth = 2**ADDR_W words of 16 bits.
- SYNC_STAGES, 2, synchronizer depth on all incoming pins (minimum 2).
- READ_LAT, 4, sysclk cycles after the synchronized OE/CE assertion before data is driven.
- INIT_VAL, 16'h0000, power-up value of every storage word (simulation/FPGA init only, not reset).

Ports:
- sysclk  in  1  system clock, 100 MHz nominal.
- rst_n  in  1  asynchronous active-low reset.
- MEM_ADDR  in  26  address from initiator.
- MEM_CEN  in  1  chip enable, active low.
- MEM_OEN  in  1  output enable, active low.
- MEM_WEN  in  1  write enable, active low.
- MEM_LBN  in  1  low-byte enable, active low.
- MEM_UBN  in  1  high-byte enable, active low.
- MEM_ADV  in  1  address valid; must be held low (async mode).
- MEM_DATA  inout  16  shared data bus.
- busy  out  1  high while the FSM is outside IDLE.
- wr_count  out  16  number of committed writes; wraps at 16'hFFFF->0.
- rd_count  out  16  number of completed reads; wraps.
- addr_oor  out  1  sticky: an access used nonzero MEM_ADDR[25:ADDR_W].
- adv_err  out  1  sticky: MEM_ADV was seen high while CEN was low.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM goes to IDLE, bus driver disabled, synchronizers loaded with inactive (1) values.
  - busy, addr_oor, adv_err = 0; wr_count, rd_count = 0.
  - Storage contents are NOT cleared.
- Input sync: CEN/OEN/WEN/LBN/UBN/ADV pass through SYNC_STAGES flops. ADDR and DATA pass through the same depth, so synchronized controls and sampled ADDR/DATA stay aligned.
- Address: word index = synchronized ADDR[ADDR_W-1:0], aliasing modulo depth. If the upper bits are nonzero during any access, set addr_oor.
- FSM states: IDLE, RD_WAIT, RD_DRIVE, WR_ACTIVE.
- IDLE:
  - sCEN low and sWEN low -> WR_ACTIVE. WEN wins if OEN is also low.
  - sCEN low, sOEN low, sWEN high -> RD_WAIT; latency counter cleared.
  - Otherwise stay in IDLE.
- RD_WAIT:
  - Counter increments each cycle. At count READ_LAT-1, latch storage[index] into rd_data and go to RD_DRIVE.
  - sCEN or sOEN high before then -> IDLE, rd_count unchanged.
- RD_DRIVE:
  - Bus enable = state==RD_DRIVE AND raw MEM_OEN low AND raw MEM_CEN low. The raw-pin gating is combinational so the bus releases with no sync delay, avoiding contention.
  - MEM_DATA = rd_data, full 16 bits; byte enables are ignored on reads.
  - On sCEN or sOEN high: increment rd_count, go to IDLE.
  - If the address changes while in this state, re-latch rd_data the following cycle (page-less async read).
- WR_ACTIVE:
  - Each cycle, hold the latest synchronized DATA, ADDR, LBN and UBN.
  - On sWEN or sCEN rising (either first): commit with the held values. storage[idx][7:0] is written if LBN was low; [15:8] if UBN was low. Then increment wr_count and go to IDLE.
  - Both byte enables high: no storage change, wr_count still increments.
- Bus is never driven in IDLE, RD_WAIT or WR_ACTIVE.
- busy = (state != IDLE), registered.
- Any sampled ADV high with sCEN low sets adv_err; the access still proceeds.
- Reset mid-operation: a write in progress is discarded (no commit); a read releases the bus immediately.
- Timing at 100 MHz (10-cycle controller read, 9-cycle write strobe): read data is valid on the bus by cycle SYNC_STAGES+READ_LAT+1 = 7 after OE falls.

Decomposition:
- Shared package psram_pkg: FSM state encoding, bus width 16, pin address width 26, inactive pin level constant.
- One natural sub-module, psram_pin_sync: a parameterized SYNC_STAGES-deep synchronizer covering the control, address and data bundle, instantiated once.
- Storage is an inferred RAM inside the top module.

Test Plan:
- Write 16'h1234 to addr 26'h5, both bytes (WEN low 9 cycles), then read addr 5 -> bus shows 16'h1234 by cycle 7 of OE low; wr_count=1, rd_count=1.
- Write 16'hAB00 with UBN=0, LBN=1 over stored 16'h1234 at addr 5 -> readback 16'hAB34.
- Read with OE low only 3 cycles -> bus never driven, rd_count unchanged, FSM back in IDLE.
- WEN and OEN low together at addr 2 with data 16'h00FF -> write wins, bus undriven, readback 16'h00FF.
- Access at address 26'h400 (ADDR_W=10) -> aliases to word 0, addr_oor=1 and stays set until reset.
- Assert rst_n low mid-write of 16'hBEEF to addr 3 -> addr 3 keeps its old value, counters 0, bus released within the reset assertion.

Source files
------------

// File: rtl/psram_pkg.sv
// Shared types and constants for the async PSRAM responder: pin bundle layout,
// FSM encoding and the inactive pin level used when flushing the synchronizers.
package psram_pkg;

  localparam int   DATA_W       = 16;
  localparam int   PIN_ADDR_W   = 26;
  localparam logic PIN_INACTIVE = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_DRIVE,
    WR_ACTIVE
  } state_t;

  // Everything sampled from the initiator travels together so the
  // synchronized controls always line up with the address/data they qualify.
  typedef struct packed {
    logic [PIN_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
    logic                  cen;
    logic                  oen;
    logic                  wen;
    logic                  lbn;
    logic                  ubn;
    logic                  adv;
  } pins_t;

  localparam pins_t PINS_IDLE = '{
    addr: '0,
    data: '0,
    cen:  PIN_INACTIVE,
    oen:  PIN_INACTIVE,
    wen:  PIN_INACTIVE,
    lbn:  PIN_INACTIVE,
    ubn:  PIN_INACTIVE,
    adv:  PIN_INACTIVE
  };

endpackage

// File: rtl/psram_pin_sync.sv
// Multi-flop synchronizer for the whole initiator pin bundle. STAGES must be
// at least 2; reset parks every stage at the inactive pin levels.
module psram_pin_sync
  import psram_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic  sysclk,
  input  logic  rst_n,
  input  pins_t d,
  output pins_t q
);

  pins_t stage_q [STAGES];

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the value its predecessor held before this edge.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= PINS_IDLE;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/async_psram_responder.sv
// Cycle-true stand-in for a 16-bit asynchronous PSRAM: synchronizes the pins,
// serves reads after a programmable latency and commits byte-masked writes.
module async_psram_responder
  import psram_pkg::*;
#(
  parameter int          ADDR_W      = 10,
  parameter int          SYNC_STAGES = 2,
  parameter int          READ_LAT    = 4,
  parameter logic [15:0] INIT_VAL    = 16'h0000
) (
  input  logic                  sysclk,
  input  logic                  rst_n,
  input  logic [PIN_ADDR_W-1:0] MEM_ADDR,
  input  logic                  MEM_CEN,
  input  logic                  MEM_OEN,
  input  logic                  MEM_WEN,
  input  logic                  MEM_LBN,
  input  logic                  MEM_UBN,
  input  logic                  MEM_ADV,
  inout  wire  [DATA_W-1:0]     MEM_DATA,
  output logic                  busy,
  output logic [15:0]           wr_count,
  output logic [15:0]           rd_count,
  output logic                  addr_oor,
  output logic                  adv_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = $clog2(READ_LAT + 1);

  pins_t pin_raw;
  pins_t s;

  assign pin_raw = '{
    addr: MEM_ADDR,
    data: MEM_DATA,
    cen:  MEM_CEN,
    oen:  MEM_OEN,
    wen:  MEM_WEN,
    lbn:  MEM_LBN,
    ubn:  MEM_UBN,
    adv:  MEM_ADV
  };

  psram_pin_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .d      (pin_raw),
    .q      (s)
  );

  logic [DATA_W-1:0] mem [DEPTH] = '{default: INIT_VAL};

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  lat_cnt;
  logic [ADDR_W-1:0] hold_idx;
  logic [DATA_W-1:0] hold_data;
  logic              hold_lbn;
  logic              hold_ubn;
  logic [DATA_W-1:0] rd_data;
  logic              bus_oe;
  logic              cnt_clr;
  logic              rd_latch;
  logic              rd_done;
  logic              commit;
  logic              hold_load;
  logic              access;

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    rd_latch   = 1'b0;
    rd_done    = 1'b0;
    commit     = 1'b0;
    hold_load  = 1'b0;
    case (state)
      IDLE: begin
        if (!s.cen && !s.wen) begin
          state_next = WR_ACTIVE;
          hold_load  = 1'b1;
        end else if (!s.cen && !s.oen) begin
          state_next = RD_WAIT;
          cnt_clr    = 1'b1;
        end
      end
      RD_WAIT: begin
        if (s.cen || s.oen) begin
          state_next = IDLE;
        end else if (lat_cnt == CNT_W'(READ_LAT - 1)) begin
          state_next = RD_DRIVE;
          rd_latch   = 1'b1;
        end
      end
      RD_DRIVE: begin
        if (s.cen || s.oen) begin
          state_next = IDLE;
          rd_done    = 1'b1;
        end else begin
          // Re-reading every cycle makes an address change show up one cycle later.
          rd_latch = 1'b1;
        end
      end
      WR_ACTIVE: begin
        if (s.wen || s.cen) begin
          state_next = IDLE;
          commit     = 1'b1;
        end else begin
          hold_load = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign access = !s.cen && (!s.wen || !s.oen);

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      busy      <= 1'b0;
      wr_count  <= '0;
      rd_count  <= '0;
      addr_oor  <= 1'b0;
      adv_err   <= 1'b0;
      hold_idx  <= '0;
      hold_data <= '0;
      hold_lbn  <= PIN_INACTIVE;
      hold_ubn  <= PIN_INACTIVE;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      if (cnt_clr)               lat_cnt <= '0;
      else if (state == RD_WAIT) lat_cnt <= lat_cnt + CNT_W'(1);
      if (hold_load) begin
        hold_idx  <= s.addr[ADDR_W-1:0];
        hold_data <= s.data;
        hold_lbn  <= s.lbn;
        hold_ubn  <= s.ubn;
      end
      if (commit)  wr_count <= wr_count + 16'd1;
      if (rd_done) rd_count <= rd_count + 16'd1;
      if (access && (|s.addr[PIN_ADDR_W-1:ADDR_W])) addr_oor <= 1'b1;
      if (s.adv && !s.cen) adv_err <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset so it maps onto block RAM and keeps
  // its contents across rst_n, exactly like the real part.
  always_ff @(posedge sysclk) begin
    if (commit) begin
      if (!hold_lbn) mem[hold_idx][7:0]  <= hold_data[7:0];
      if (!hold_ubn) mem[hold_idx][15:8] <= hold_data[15:8];
    end
    if (rd_latch) rd_data <= mem[s.addr[ADDR_W-1:0]];
  end

  // Raw-pin gating lets the bus turn around the moment the initiator lets go.
  assign bus_oe   = (state == RD_DRIVE) && !MEM_OEN && !MEM_CEN;
  assign MEM_DATA = bus_oe ? rd_data : 'z;

endmodule

// File: tb/tb_async_psram_responder.sv
// Self-checking bench: each pin transaction is scored cycle by cycle against
// timing and storage rules computed from the transaction's length and fields.
module tb_async_psram_responder;

  localparam int SYNC = 2;
  localparam int RL   = 4;
  localparam int AW   = 10;
  localparam int D    = SYNC + RL + 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [25:0] addr;
  logic        cen, oen, wen, lbn, ubn, adv;
  logic        tb_drive;
  logic [15:0] tb_data;
  wire  [15:0] mem_data;
  logic        busy;
  logic [15:0] wr_count, rd_count;
  logic        addr_oor, adv_err;

  assign mem_data = tb_drive ? tb_data : 16'hzzzz;

  always #5 clk = ~clk;

  async_psram_responder #(
    .ADDR_W(AW), .SYNC_STAGES(SYNC), .READ_LAT(RL), .INIT_VAL(16'h0000)
  ) dut (
    .sysclk   (clk),
    .rst_n    (rst_n),
    .MEM_ADDR (addr),
    .MEM_CEN  (cen),
    .MEM_OEN  (oen),
    .MEM_WEN  (wen),
    .MEM_LBN  (lbn),
    .MEM_UBN  (ubn),
    .MEM_ADV  (adv),
    .MEM_DATA (mem_data),
    .busy     (busy),
    .wr_count (wr_count),
    .rd_count (rd_count),
    .addr_oor (addr_oor),
    .adv_err  (adv_err)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  logic [15:0] model_mem [1 << AW];
  logic        exp_busy, exp_drive, exp_oor, exp_adv;
  logic [15:0] exp_wr, exp_rd, exp_data;
  int          drv;
  logic [15:0] bus;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_pins();
    cen = 1'b1; oen = 1'b1; wen = 1'b1; lbn = 1'b1; ubn = 1'b1; adv = 1'b0;
    addr = '0; tb_drive = 1'b0; tb_data = '0;
  endtask

  task automatic clear_expect();
    exp_busy = 1'b0; exp_drive = 1'b0; exp_oor = 1'b0; exp_adv = 1'b0;
    exp_wr = '0; exp_rd = '0; exp_data = '0;
  endtask

  task automatic compare_cycle();
    check("busy",     busy,       exp_busy);
    check("wr_count", wr_count,   exp_wr);
    check("rd_count", rd_count,   exp_rd);
    check("addr_oor", addr_oor,   exp_oor);
    check("adv_err",  adv_err,    exp_adv);
    check("bus_oe",   dut.bus_oe, exp_drive);
    if (exp_drive) check("bus_data", mem_data, exp_data);
  endtask

  // Reset asserted mid-transaction, 2 ns after an edge; bus and counters must clear at once.
  task automatic reset_now();
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy",   busy,       1'b0);
    check("rst_wr",     wr_count,   16'h0);
    check("rst_rd",     rd_count,   16'h0);
    check("rst_oor",    addr_oor,   1'b0);
    check("rst_adv",    adv_err,    1'b0);
    check("rst_bus_oe", dut.bus_oe, 1'b0);
    idle_pins();
    clear_expect();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One transaction with pins held active for len cycles; expectations follow
  // from len: the sampled view lags the pins by SYNC cycles, the FSM one more.
  task automatic run_op(input bit is_rd, input bit both, input logic [25:0] a,
                        input logic [15:0] d, input bit lb, input bit ub, input bit av,
                        input int len, input int rst_at,
                        output int n_drv, output logic [15:0] last_bus);
    int idx;
    idx      = int'(a[AW-1:0]);
    n_drv    = 0;
    last_bus = '0;
    addr = a; cen = 1'b0; adv = av; lbn = lb; ubn = ub;
    if (is_rd) begin
      oen = 1'b0;
    end else begin
      wen = 1'b0; oen = !both; tb_drive = 1'b1; tb_data = d;
    end
    for (int k = 1; k <= len + SYNC + 2; k++) begin
      @(posedge clk);
      if (k == rst_at) begin
        reset_now();
        return;
      end
      #1;
      if (k == len) idle_pins();
      exp_busy  = (k >= SYNC + 1) && (k <= len + SYNC);
      exp_drive = is_rd && (k >= D) && (k < len);
      exp_data  = model_mem[idx];
      if (k == SYNC + 1) begin
        if (a[25:AW] != '0) exp_oor = 1'b1;
        if (av) exp_adv = 1'b1;
      end
      if (k == len + SYNC + 1) begin
        if (is_rd) begin
          if (len >= RL + 1) exp_rd = exp_rd + 16'd1;
        end else begin
          exp_wr = exp_wr + 16'd1;
          if (!lb) model_mem[idx][7:0]  = d[7:0];
          if (!ub) model_mem[idx][15:8] = d[15:8];
        end
      end
      @(negedge clk);
      compare_cycle();
      if (dut.bus_oe) begin
        n_drv++;
        last_bus = mem_data;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) model_mem[i] = 16'h0000;
    idle_pins();
    clear_expect();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("init_busy", busy, 1'b0);
    check("init_wr",   wr_count, 16'h0);
    check("init_rd",   rd_count, 16'h0);
    check("init_oor",  addr_oor, 1'b0);
    check("init_adv",  adv_err, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full-word write then 10-cycle read; data visible from cycle 7 of OE low.
    run_op(0, 0, 26'h5, 16'h1234, 0, 0, 0, 9, 0, drv, bus);
    run_op(1, 0, 26'h5, 16'h0000, 0, 0, 0, 10, 0, drv, bus);
    check("t1_rd_data", bus, 16'h1234);
    check("t1_drv_cyc", drv, 3);
    check("t1_wr_count", wr_count, 16'd1);
    check("t1_rd_count", rd_count, 16'd1);

    // Upper byte only.
    run_op(0, 0, 26'h5, 16'hAB00, 1, 0, 0, 9, 0, drv, bus);
    run_op(1, 0, 26'h5, 16'h0000, 0, 0, 0, 10, 0, drv, bus);
    check("t2_rd_data", bus, 16'hAB34);

    // Short read aborts before the latency expires.
    run_op(1, 0, 26'h5, 16'h0000, 0, 0, 0, 3, 0, drv, bus);
    check("t3_drv_cyc", drv, 0);
    check("t3_rd_count", rd_count, 16'd2);
    check("t3_busy", busy, 1'b0);

    // WEN and OEN together: the write wins and the bus stays released.
    run_op(0, 1, 26'h2, 16'h00FF, 0, 0, 0, 9, 0, drv, bus);
    check("t4_drv_cyc", drv, 0);
    run_op(1, 0, 26'h2, 16'h0000, 0, 0, 0, 10, 0, drv, bus);
    check("t4_rd_data", bus, 16'h00FF);
    check("t4_wr_count", wr_count, 16'd3);
    check("t4_rd_count", rd_count, 16'd3);

    // Out-of-range address aliases onto word 0 and sets the sticky flag.
    check("t5_oor_before", addr_oor, 1'b0);
    run_op(0, 0, 26'h400, 16'hC0DE, 0, 0, 0, 9, 0, drv, bus);
    check("t5_oor_after", addr_oor, 1'b1);
    run_op(1, 0, 26'h0, 16'h0000, 0, 0, 0, 10, 0, drv, bus);
    check("t5_alias_data", bus, 16'hC0DE);

    // Randomized traffic over a 16-word window, every word known first.
    for (int i = 0; i < 16; i++)
      run_op(0, 0, 26'(i), 16'($urandom), 0, 0, 0, $urandom_range(1, 12), 0, drv, bus);
    for (int n = 0; n < 150; n++) begin
      int          kind;
      logic [25:0] a;
      kind = $urandom_range(0, 2);
      a    = 26'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) a[25:AW] = 16'($urandom);
      run_op(kind == 0, kind == 2, a, 16'($urandom), 1'($urandom), 1'($urandom),
             $urandom_range(0, 9) == 0, $urandom_range(1, 12), 0, drv, bus);
    end
    check("oor_sticky", addr_oor, 1'b1);

    // Reset in the middle of a write discards it.
    run_op(0, 0, 26'h3, 16'h3333, 0, 0, 0, 9, 0, drv, bus);
    run_op(0, 0, 26'h3, 16'hBEEF, 0, 0, 0, 9, 6, drv, bus);
    run_op(1, 0, 26'h3, 16'h0000, 0, 0, 0, 10, 0, drv, bus);
    check("t6_kept_data", bus, 16'h3333);
    check("t6_wr_count", wr_count, 16'd0);
    check("t6_rd_count", rd_count, 16'd1);
    check("t6_oor_clear", addr_oor, 1'b0);

    // Reset while the bus is being driven releases it immediately.
    run_op(1, 0, 26'h3, 16'h0000, 0, 0, 0, 12, 9, drv, bus);
    check("t7_drove_before_rst", drv, 2);
    repeat (2) @(posedge clk);
    #1;
    check("t7_idle_after", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
